// File: rtl/alu_if.sv
// alu_if: operand/opcode bus into the ALU and registered result/flags back out.
interface alu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALU_control;
  logic [3:0]  ALU_flags;
  logic [31:0] outputC;
  modport master (output A, B, ALU_control, input ALU_flags, outputC);
  modport slave  (input A, B, ALU_control, output ALU_flags, outputC);
endinterface

// File: rtl/alu.sv
// alu: 32-bit single-cycle registered ALU producing result and NZCV flags.
module alu (
  input logic clk,
  input logic reset,
  alu_if.slave bus
);
  logic [31:0] r_result;
  logic [3:0]  r_flags;
  logic [31:0] w_r;
  logic        w_c;
  logic        w_v;
  logic [32:0] w_add;
  logic [32:0] w_sub;
  logic [32:0] w_shl;
  logic [32:0] w_shr;
  logic        w_big;
  // add and add-with-carry share one adder; carry-in comes from the registered C flag
  assign w_add = {1'b0, bus.A} + {1'b0, bus.B} + {32'd0, bus.ALU_control == 4'b0111 && r_flags[1]};
  assign w_sub = {1'b0, bus.A} - {1'b0, bus.B};
  assign w_big = |bus.B[31:6] || bus.B[5:0] > 6'd32;
  // the extra bit catches the last bit shifted out, which becomes C
  assign w_shl = {1'b0, bus.A} << bus.B[5:0];
  assign w_shr = {bus.A, 1'b0} >> bus.B[5:0];
  always_comb begin
    w_r = bus.A;
    w_c = 1'b0;
    w_v = 1'b0;
    case (bus.ALU_control)
      4'b0001, 4'b0111: begin
        w_r = w_add[31:0];
        w_c = w_add[32];
        w_v = bus.A[31] == bus.B[31] && w_add[31] != bus.A[31];
      end
      4'b0010: begin
        w_r = w_sub[31:0];
        w_c = ~w_sub[32];
        w_v = bus.A[31] != bus.B[31] && w_sub[31] != bus.A[31];
      end
      4'b0011: w_r = bus.A * bus.B;
      4'b0100: begin
        w_r = bus.B == 32'd0 ? 32'd0 : bus.A / bus.B;
        w_v = bus.B == 32'd0;
      end
      4'b0101: begin
        w_r = w_big ? 32'd0 : w_shl[31:0];
        w_c = !w_big && w_shl[32];
      end
      4'b0110: begin
        w_r = w_big ? 32'd0 : w_shr[32:1];
        w_c = !w_big && w_shr[0];
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= 32'd0;
      r_flags  <= 4'd0;
    end else if (!bus.ALU_control[3]) begin
      r_result <= w_r;
      r_flags  <= {w_r[31], w_r == 32'd0, w_c, w_v};
    end
  end
  assign bus.outputC   = r_result;
  assign bus.ALU_flags = r_flags;
endmodule

// File: tb/tb_alu.sv
// tb_alu: table-driven scoreboard bench for the registered ALU.
module tb_alu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  alu_if bus ();
  alu dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;
  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          id;
  } exp_t;
  exp_t sb[$];
  vec_t tv[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s #%0d got %h expected %h", name, id, got, exp);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [31:0] r, input logic [3:0] f, input int id);
    exp_t e;
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.ALU_control = op;
    sb.push_back('{r: r, f: f, id: id});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("result", e.id, bus.outputC, e.r);
    chk("flags", e.id, {28'd0, bus.ALU_flags}, {28'd0, e.f});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    tv.push_back('{a: 32'd4, b: 32'd6, op: 4'b0001, r: 32'd10, f: 4'b0000});
    tv.push_back('{a: 32'd4, b: 32'd6, op: 4'b0010, r: 32'hFFFFFFFE, f: 4'b1000});
    tv.push_back('{a: 32'd6, b: 32'd4, op: 4'b0010, r: 32'd2, f: 4'b0010});
    tv.push_back('{a: 32'h7FFFFFFF, b: 32'd1, op: 4'b0001, r: 32'h80000000, f: 4'b1001});
    tv.push_back('{a: 32'h80000000, b: 32'd1, op: 4'b0010, r: 32'h7FFFFFFF, f: 4'b0011});
    tv.push_back('{a: 32'd4, b: 32'd6, op: 4'b0011, r: 32'd24, f: 4'b0000});
    tv.push_back('{a: 32'h10000, b: 32'h10000, op: 4'b0011, r: 32'd0, f: 4'b0100});
    tv.push_back('{a: 32'd6, b: 32'd4, op: 4'b0100, r: 32'd1, f: 4'b0000});
    tv.push_back('{a: 32'd4, b: 32'd6, op: 4'b0100, r: 32'd0, f: 4'b0100});
    tv.push_back('{a: 32'd7, b: 32'd0, op: 4'b0100, r: 32'd0, f: 4'b0101});
    tv.push_back('{a: 32'd4, b: 32'd2, op: 4'b0101, r: 32'd16, f: 4'b0000});
    tv.push_back('{a: 32'd4, b: 32'd2, op: 4'b0110, r: 32'd1, f: 4'b0000});
    tv.push_back('{a: 32'h80000001, b: 32'd1, op: 4'b0110, r: 32'h40000000, f: 4'b0010});
    tv.push_back('{a: 32'd5, b: 32'd40, op: 4'b0101, r: 32'd0, f: 4'b0100});
    tv.push_back('{a: 32'd1, b: 32'd32, op: 4'b0101, r: 32'd0, f: 4'b0110});
    tv.push_back('{a: 32'h80000000, b: 32'd32, op: 4'b0110, r: 32'd0, f: 4'b0110});
    tv.push_back('{a: 32'h80000000, b: 32'd0, op: 4'b0101, r: 32'h80000000, f: 4'b1000});
    tv.push_back('{a: 32'd3, b: 32'd31, op: 4'b0101, r: 32'h80000000, f: 4'b1010});
    tv.push_back('{a: 32'hF0, b: 32'd33, op: 4'b0110, r: 32'd0, f: 4'b0100});
    tv.push_back('{a: 32'h80000000, b: 32'd5, op: 4'b0000, r: 32'h80000000, f: 4'b1000});
    tv.push_back('{a: 32'hFFFFFFFF, b: 32'd1, op: 4'b0001, r: 32'd0, f: 4'b0110});
    tv.push_back('{a: 32'd4, b: 32'd6, op: 4'b0111, r: 32'd11, f: 4'b0000});
    tv.push_back('{a: 32'd4, b: 32'd6, op: 4'b0111, r: 32'd10, f: 4'b0000});
    tv.push_back('{a: 32'd5, b: 32'd5, op: 4'b0010, r: 32'd0, f: 4'b0110});
    tv.push_back('{a: 32'd9, b: 32'd9, op: 4'b1111, r: 32'd0, f: 4'b0110});
    tv.push_back('{a: 32'd1, b: 32'd1, op: 4'b0111, r: 32'd3, f: 4'b0000});
    tv.push_back('{a: 32'h7FFFFFFF, b: 32'd0, op: 4'b0111, r: 32'h7FFFFFFF, f: 4'b0000});
    bus.A = 32'd4;
    bus.B = 32'd0;
    bus.ALU_control = 4'b0000;
    #2;
    chk("reset_result", 0, bus.outputC, 32'd0);
    chk("reset_flags", 0, {28'd0, bus.ALU_flags}, 32'd0);
    @(posedge clk);
    #1;
    chk("reset_hold_result", 0, bus.outputC, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(32'd4, 32'd0, 4'b0000, 32'd4, 4'b0000, 1);
    issue(32'hFFFFFFFF, 32'd0, 4'b0000, 32'hFFFFFFFF, 4'b1000, 2);
    @(negedge clk);
    bus.A = 32'd7;
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_result", 3, bus.outputC, 32'd0);
    chk("async_reset_flags", 3, {28'd0, bus.ALU_flags}, 32'd0);
    @(posedge clk);
    #1;
    chk("reset_discard", 3, bus.outputC, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    foreach (tv[i]) issue(tv[i].a, tv[i].b, tv[i].op, tv[i].r, tv[i].f, 100 + i);
    issue(32'd1, 32'd1, 4'b0001, 32'd2, 4'b0000, 200);
    issue(32'd8, 32'd8, 4'b1010, 32'd2, 4'b0000, 201);
    issue(32'd5, 32'd3, 4'b0010, 32'd2, 4'b0010, 202);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu.md
# alu

- 32-bit registered arithmetic/logic unit for the execute stage of the pipelined ARM-style core.
- Takes two operands and a 4-bit operation select.
- Produces a 32-bit result and a 4-bit NZCV flag vector, both registered on the rising clock edge.
- Feeds result forwarding and condition evaluation in later stages.

## Interface
- No parameters; data width fixed at 32, control and flag width fixed at 4.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all registered outputs
- A  input  32  operand A
- B  input  32  operand B; also the shift amount for shift operations
- ALU_control  input  4  operation select
- ALU_flags  output  4  registered flags: [3]=N, [2]=Z, [1]=C, [0]=V
- outputC  output  32  registered result

## Operation
- Opcodes, with R = next result:
  - 0000 pass: R = A; C=0, V=0.
  - 0001 add: R = A+B; C = carry out of bit 31; V = signed overflow.
  - 0010 subtract: R = A−B; C = 1 when A ≥ B unsigned (no borrow, ARM convention); V = signed overflow.
  - 0011 multiply: R = low 32 bits of unsigned A×B; C=0, V=0.
  - 0100 divide: R = unsigned A/B, truncated; C=0, V=0.
    - Divide by zero (B=0): R = 0, V=1.
  - 0101 shift left logical: R = A << B.
    - B = 0: R = A, C=0.
    - 1 ≤ B ≤ 32: C = last bit shifted out, i.e. A[32−B]; for B=32 that is A[0].
    - B > 32: R = 0, C=0.
    - V=0.
  - 0110 shift right logical: R = A >> B, zero fill.
    - B = 0: R = A, C=0.
    - 1 ≤ B ≤ 32: C = last bit shifted out, i.e. A[B−1]; for B=32 that is A[31].
    - B > 32: R = 0, C=0.
    - V=0.
  - 0111 add with carry: R = A+B+C, where C is the currently registered ALU_flags[1].
    - C = carry out of bit 31 of the 33-bit sum; V = signed overflow.
  - 1000–1111 reserved: outputC and ALU_flags hold their previous values.
- For every defined opcode: N = R[31]; Z = (R == 0).
- All arithmetic is two's complement modulo 2^32; multiply and divide treat operands as unsigned.
- Signed overflow V for add forms: operands share a sign and the result sign differs.
- Signed overflow V for subtract: operand signs differ and the result sign differs from A.
- Divide may be implemented combinationally; it must complete within one clock period at the target frequency.

## Timing
- Latency: one cycle. Inputs sampled at rising edge k; outputC and ALU_flags valid after edge k, held until edge k+1.
- One operation is accepted every cycle. No handshake, no stall, no busy state.
- Reset:
  - On reset assertion, outputC = 0 and ALU_flags = 0000 immediately, with no clock needed.
  - While reset is high, outputs stay at zero regardless of inputs or clock.
  - The first operation after deassertion is sampled at the first rising edge with reset low.
  - Reset asserted mid-stream discards the pending operation.
- Add-with-carry uses the C flag registered before the current edge, so back-to-back ADC chains across cycles.
- Reserved opcodes in the middle of a stream leave outputs frozen; the next valid opcode updates normally.

## Test plan
- Reset and pass: reset high → outputs 0 / 0000. Release, A=4, 0000 → outputC=4, flags 0000. Pulse reset between edges → outputs clear immediately.
- Add and subtract, A=4, B=6:
  - 0001 → 10, flags 0000.
  - 0010 → 0xFFFFFFFE, flags 1000.
  - A=6, B=4, 0010 → 2, flags 0010.
  - A=0x7FFFFFFF, B=1, 0001 → 0x80000000, flags 1001.
- Multiply and divide:
  - A=4, B=6, 0011 → 24.
  - A=6, B=4, 0100 → 1.
  - A=4, B=6, 0100 → 0, flags 0100.
  - A=7, B=0, 0100 → 0, flags 0101.
- Shifts:
  - A=4, B=2, 0101 → 16.
  - A=4, B=2, 0110 → 1, flags 0000.
  - A=0x80000001, B=1, 0110 → 0x40000000, flags 0010.
  - A=5, B=40, 0101 → 0, flags 0100.
- Add-with-carry chain:
  - A=0xFFFFFFFF, B=1, 0001 → 0, flags 0110.
  - Next cycle A=4, B=6, 0111 → 11, flags 0000.
  - Next cycle 0111 again → 10.
- Reserved opcode and throughput:
  - Issue 0001 (A=1, B=1), then 1010, then 0010 (A=5, B=3) on consecutive cycles.
  - Outputs read 2, 2, 2 across the three cycles, then flags 0010 after the third edge.
